// File: rtl/seven_segment_capture.sv
// Monitors a time-multiplexed, active-low seven-segment bus and recovers the
// hex value shown on each digit once its (anode, seg) pattern has been stable.
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   anode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    pattern_err,
  output logic                    anode_conflict,
  output logic                    err_sticky
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] HELD  = 2'd2;

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

  logic [6:0]            seg_q;
  logic [6:0]            seg_prev;
  logic [NUM_DIGITS-1:0] anode_q;
  logic [NUM_DIGITS-1:0] anode_prev;
  logic [1:0]            state;
  logic [7:0]            run_count;
  logic [7:0]            run_inc;

  logic       one_hot;
  logic       multi_now;
  logic       multi_prev;
  logic       same_pair;
  logic       pat_known;
  logic       pat_blank;
  logic [3:0] pat_hex;

  function automatic logic [3:0] count_low(input logic [NUM_DIGITS-1:0] a);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      n = n + {3'b000, ~a[i]};
    end
    return n;
  endfunction

  assign one_hot    = (count_low(anode_q) == 4'd1);
  assign multi_now  = (count_low(anode_q) > 4'd1);
  assign multi_prev = (count_low(anode_prev) > 4'd1);
  assign same_pair  = (anode_q == anode_prev) && (seg_q == seg_prev);
  assign run_inc    = (run_count == 8'hFF) ? run_count : run_count + 8'd1;

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave a value unassigned and infer a latch.
  always_comb begin
    pat_known = 1'b1;
    pat_blank = 1'b0;
    pat_hex   = 4'h0;
    case (seg_q)
      7'b1000000: pat_hex = 4'h0;
      7'b1111001: pat_hex = 4'h1;
      7'b0100100: pat_hex = 4'h2;
      7'b0110000: pat_hex = 4'h3;
      7'b0011001: pat_hex = 4'h4;
      7'b0010010: pat_hex = 4'h5;
      7'b0000010: pat_hex = 4'h6;
      7'b1111000: pat_hex = 4'h7;
      7'b0000000: pat_hex = 4'h8;
      7'b0011000: pat_hex = 4'h9;
      7'b0001000: pat_hex = 4'hA;
      7'b0000011: pat_hex = 4'hB;
      7'b1000110: pat_hex = 4'hC;
      7'b0100001: pat_hex = 4'hD;
      7'b0000110: pat_hex = 4'hE;
      7'b0001110: pat_hex = 4'hF;
      7'b1111111: begin
        pat_known = 1'b0;
        pat_blank = 1'b1;
      end
      default:    pat_known = 1'b0;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, which is what makes seg_prev lag seg_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q          <= '1;
      seg_prev       <= '1;
      anode_q        <= '1;
      anode_prev     <= '1;
      state          <= IDLE;
      run_count      <= '0;
      digits         <= '0;
      digit_valid    <= '0;
      update         <= 1'b0;
      pattern_err    <= 1'b0;
      anode_conflict <= 1'b0;
      err_sticky     <= 1'b0;
    end else begin
      seg_q      <= seg;
      anode_q    <= anode;
      seg_prev   <= seg_q;
      anode_prev <= anode_q;

      update         <= 1'b0;
      pattern_err    <= 1'b0;
      anode_conflict <= multi_now && !multi_prev;

      if (!one_hot) begin
        state     <= IDLE;
        run_count <= '0;
      end else if (state == IDLE || !same_pair) begin
        state     <= COUNT;
        run_count <= 8'd1;
      end else begin
        run_count <= run_inc;
        if (state == COUNT && run_inc == STABLE_LIMIT) begin
          state <= HELD;
          // The selected digit is the single low anode bit.
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!anode_q[i]) begin
              if (pat_blank) begin
                digits[4*i +: 4] <= 4'h0;
                digit_valid[i]   <= 1'b0;
              end else if (pat_known) begin
                digits[4*i +: 4] <= pat_hex;
                digit_valid[i]   <= 1'b1;
              end
            end
          end
          if (pat_blank || pat_known) begin
            update <= 1'b1;
          end else begin
            pattern_err <= 1'b1;
            err_sticky  <= 1'b1;
          end
        end
      end
    end
  end

endmodule
